// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execute-stage blocks.
// Holds the M-extension operation codes, the mul/div FSM states and its write-back select.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam logic [2:0] WRITESEL_MULDIV = 3'b011;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// one bit per clock, with sign fix-up and divide special cases applied in a single FIX cycle.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t    state;
  muldiv_op_t       op;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             neg;
  logic             div_zero;
  logic             ovf;

  // Accept-time operand conditioning: magnitudes, result sign and special-case flags.
  logic             a_signed, b_signed, a_sgn, b_sgn, is_rem_req, is_sdiv_req;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    a_signed    = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                  (funct3 == OP_DIV)  || (funct3 == OP_REM);
    b_signed    = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    a_sgn       = a_signed && a[WIDTH-1];
    b_sgn       = b_signed && b[WIDTH-1];
    a_abs       = a_sgn ? (~a + 1'b1) : a;
    b_abs       = b_sgn ? (~b + 1'b1) : b;
    is_rem_req  = (funct3 == OP_REM) || (funct3 == OP_REMU);
    is_sdiv_req = (funct3 == OP_DIV) || (funct3 == OP_REM);
  end

  // One iteration step for each algorithm; acc holds {hi, lo} or {remainder, quotient}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[cnt] ? {1'b0, opa} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], opa[CW'(WIDTH-1) - cnt]};
    diff     = {1'b0, rem_sh} - {2'b00, opb};
    q_bit    = ~diff[WIDTH+1];
    div_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
  end

  // Sign fix-up, word select and special-case override feeding the result register.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, a_back, fix_result;

  always_comb begin
    prod_s = neg ? (~acc + 1'b1) : acc;
    quo_s  = neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_s  = neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    // For remainders neg is the sign of a, so this rebuilds the original dividend.
    a_back = neg ? (~opa + 1'b1) : opa;
    fix_result = '0;
    case (op)
      OP_MUL:                        fix_result = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               fix_result = div_zero ? '1 : (ovf ? MIN_NEG : quo_s);
      OP_REM, OP_REMU:               fix_result = div_zero ? a_back : (ovf ? '0 : rem_s);
      default:                       fix_result = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op       <= OP_MUL;
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op       <= muldiv_op_t'(funct3);
            opa      <= a_abs;
            opb      <= b_abs;
            neg      <= is_rem_req ? a_sgn : (a_sgn ^ b_sgn);
            div_zero <= (b == '0);
            ovf      <= is_sdiv_req && (a == MIN_NEG) && (b == '1);
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          result <= fix_result;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          // A start still held here belongs to the instruction just finished.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = ((state == IDLE) && start) || (state == RUN) || (state == FIX);

endmodule
